// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the valid/ready skid stage.
//   state_t : occupancy state of the stage
//             ST_EMPTY = 0 words held
//             ST_BUSY  = main register full
//             ST_FULL  = main and skid registers full
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Number of held words for a given state.
  function automatic logic [1:0] state_occ(input state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_EMPTY: n = 2'd0;
      ST_BUSY:  n = 2'd1;
      ST_FULL:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_dffl.sv
// dffl: DW-bit load-enabled register with asynchronous active-low clear.
//   clk   : clock, rising edge
//   rst_n : async active-low reset, clears q to 0
//   en    : load enable, q <= d when high
//   d     : data in
//   q     : registered data out
module dffl #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: registered valid/ready pipeline stage with a one-entry
// skid buffer. Full throughput, 1-cycle latency, and i_ready is a pure
// function of the state register (no o_ready -> i_ready path).
//   clk     : core clock
//   rst_n   : async active-low reset
//   flush   : synchronous discard of all held words
//   i_valid : upstream word present on i_data
//   i_ready : stage can accept a word this cycle
//   i_data  : upstream data
//   o_valid : o_data holds a valid word
//   o_ready : downstream accepts o_data this cycle
//   o_data  : head word (main register)
//   occ     : number of words held, 0..2
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    occ
);

  state_t        state, state_nxt;
  logic          in_xfer, out_xfer;
  logic          main_en, skid_en;
  logic [DW-1:0] main_d, skid_q;

  assign in_xfer  = i_valid & i_ready;
  assign out_xfer = o_valid & o_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_xfer) state_nxt = ST_BUSY;
        ST_BUSY: begin
          if (in_xfer && !out_xfer)      state_nxt = ST_FULL;
          else if (!in_xfer && out_xfer) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (out_xfer) state_nxt = ST_BUSY;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Outputs and register load controls. Flush gates both enables so the
  // data registers keep their stale contents.
  always_comb begin
    o_valid = (state != ST_EMPTY);
    i_ready = (state != ST_FULL);
    occ     = state_occ(state);
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = i_data;
    if (!flush) begin
      case (state)
        ST_EMPTY: main_en = in_xfer;
        ST_BUSY: begin
          main_en = in_xfer & out_xfer;
          skid_en = in_xfer & ~out_xfer;
        end
        ST_FULL: begin
          main_en = out_xfer;
          main_d  = skid_q;
        end
        default: ;
      endcase
    end
  end

  dffl #(.W(DW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (o_data)
  );

  dffl #(.W(DW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (i_data),
    .q     (skid_q)
  );

endmodule
